lq_idx_alloc_ctrl: RTL and testbench
====================================

// Module: lq_idx_alloc_ctrl
// PURPOSE
//  Allocation controller for the load queue index space (lqIdx_t = {flipped, idx}).
//  Sits between rename/dispatch and the LQ. Hands out up to ALLOC_WIDTH consecutive
//  lqIdx per cycle and reclaims up to FREE_WIDTH entries per cycle in order from head.
//  Rolls tail back on pipeline squash, then stalls allocation one cycle for the LQ flush.
// PARAMETERS
//  LQ_SIZE      `LQSIZE (64)  entries; must be a power of two; IDXW = $clog2(LQ_SIZE)
//  ALLOC_WIDTH  4             dispatch slots per cycle
//  FREE_WIDTH   2             LQ entries retired per cycle
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  asynchronous, active-low reset
//  i_alloc_req   in   ALLOC_WIDTH        per-slot LQ entry request
//  i_alloc_fire  in   1                  dispatch handshake completes this cycle
//  o_can_alloc   out  1                  all requested slots fit; combinational
//  o_alloc_idx   out  ALLOC_WIDTH x lqIdx_t  index per slot; combinational
//  i_free_vld    in   FREE_WIDTH         retire mask; popcount = entries freed at head
//  i_squash      in   1                  flush younger loads
//  i_squash_idx  in   lqIdx_t            oldest discarded entry = new tail
//  o_head        out  lqIdx_t            oldest live entry
//  o_tail        out  lqIdx_t            next entry to allocate
//  o_count       out  IDXW+1             live entries
//  o_empty/o_full out 1 each             count==0 / count==LQ_SIZE
// BEHAVIOUR
//  - Reset (rst=0, async): head=tail={0,0}, state=RUN, count=0, empty=1, full=0,
//    o_can_alloc=0 while rst is low. All state is registered; outputs derive from it.
//  - Pointer advance: {flipped,idx} + n with idx wrap at LQ_SIZE toggling flipped.
//  - count = (head.flipped==tail.flipped) ? tail.idx-head.idx : LQ_SIZE-head.idx+tail.idx.
//  - o_alloc_idx[k] = tail + popcount(i_alloc_req[k-1:0]). Valid only where req[k]=1;
//    a non-contiguous mask is legal and packs the indices.
//  - o_can_alloc = state==RUN && !i_squash && (LQ_SIZE-count) >= popcount(i_alloc_req).
//    Frees in the same cycle are not credited. All-or-nothing per cycle.
//  - Allocation: on i_alloc_fire && o_can_alloc, tail += popcount(req) next edge.
//    i_alloc_fire while !o_can_alloc is ignored.
//  - Free: head += popcount(i_free_vld) every cycle, in every state and with squash.
//    Freeing more than count is illegal (assertion).
//  - Squash: when i_squash=1, tail <= i_squash_idx next edge and no allocation occurs.
//    State moves RUN->SQ_WAIT; squash_idx == tail is a legal no-op rollback.
//  - State machine:
//    RUN -> SQ_WAIT on i_squash.
//    SQ_WAIT -> RUN after one cycle, unless i_squash again (stays SQ_WAIT, tail reloads).
//    o_can_alloc=0 in SQ_WAIT.
//  - Latency: allocation/free/squash effects are visible on o_tail/o_head/o_count one
//    cycle after the edge. o_alloc_idx has zero-cycle latency from the registered tail.
//  - Full: count==LQ_SIZE -> o_full=1, any nonzero request refused. Zero request -> can_alloc=1.
//  - Simultaneous alloc+free at full: alloc refused this cycle, accepted next cycle.
// CONFIGURATION
//  LQ_ALLOC_PERF_EN defined: adds output o_stall_cnt [31:0], reset 0.
//    It increments (saturating) each cycle with |i_alloc_req && !o_can_alloc && rst=1.
//  LQ_ALLOC_PERF_EN undefined: no port, no counter; all other behaviour identical.
// TESTING (LQ_SIZE=64, ALLOC_WIDTH=4, FREE_WIDTH=2)
//  1. Reset, req=4'b1111+fire -> idx {0,0},{0,1},{0,2},{0,3}; next cycle tail={0,4}, count=4.
//  2. req=4'b1010+fire from tail {0,4} -> idx[1]={0,4}, idx[3]={0,5}; tail={0,6}.
//  3. 16 fires of 4'b1111 -> count=64, full=1; req=4'b0001 -> can_alloc=0.
//     Then free_vld=2'b11 -> count=62; req=4'b0011+fire -> idx {1,0},{1,1}.
//  4. Wrap: head={0,62}, tail={1,2} -> count=4. Free 2 -> head={1,0}, count=2.
//  5. tail={0,20}, squash_idx={0,12}, req=4'b1111+fire same cycle -> tail={0,12}.
//     can_alloc=0 for one cycle, then 1; a second squash in SQ_WAIT extends the stall.
//  6. Drop rst mid-run at count=30 -> head=tail={0,0}, count=0 immediately.
//     With LQ_ALLOC_PERF_EN, 3 blocked-request cycles -> o_stall_cnt=3.

Source files
------------

// File: rtl/lq_idx_alloc_ctrl.sv
// rtl/lq_idx_alloc_ctrl.sv - load queue index allocator; optional stall counter under LQ_ALLOC_PERF_EN
`ifndef LQSIZE
`define LQSIZE 64
`endif

module lq_idx_alloc_ctrl #(
    parameter  int LQ_SIZE     = `LQSIZE,
    parameter  int ALLOC_WIDTH = 4,
    parameter  int FREE_WIDTH  = 2,
    localparam int IDXW        = $clog2(LQ_SIZE),
    localparam int PW          = IDXW + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ALLOC_WIDTH-1:0]            i_alloc_req,
    input  logic                              i_alloc_fire,
    output logic                              o_can_alloc,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]    o_alloc_idx,
    input  logic [FREE_WIDTH-1:0]             i_free_vld,
    input  logic                              i_squash,
    input  logic [PW-1:0]                     i_squash_idx,
    output logic [PW-1:0]                     o_head,
    output logic [PW-1:0]                     o_tail,
    output logic [PW-1:0]                     o_count,
    output logic                              o_empty,
    output logic                              o_full
`ifdef LQ_ALLOC_PERF_EN
    ,
    output logic [31:0]                       o_stall_cnt
`endif
);

    localparam logic [PW-1:0] SIZE_P = PW'(LQ_SIZE);

    typedef enum logic {
        RUN     = 1'b0,
        SQ_WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] req_pc;
    logic [PW-1:0] free_pc;
    logic [PW-1:0] count;
    logic [PW-1:0] space;

    // Pointers carry the flip bit as their MSB, so plain PW-bit arithmetic wraps
    // idx at LQ_SIZE and toggles flipped; the difference is the live count.
    assign count   = tail - head;
    assign space   = SIZE_P - count;
    assign o_head  = head;
    assign o_tail  = tail;
    assign o_count = count;
    assign o_empty = (count == '0);
    assign o_full  = (count == SIZE_P);

    // Pack requested slots onto consecutive indices and total the retire mask
    always_comb begin
        req_pc = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            o_alloc_idx[k] = tail + req_pc;
            req_pc         = req_pc + PW'(i_alloc_req[k]);
        end
        free_pc = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            free_pc = free_pc + PW'(i_free_vld[j]);
        end
    end

    // All-or-nothing grant; same-cycle frees are not credited toward space
    always_comb begin
        o_can_alloc = rst && (state == RUN) && !i_squash && (space >= req_pc);
    end

    // Pointer and squash-stall state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
        end else begin
            head <= head + free_pc;
            if (i_squash) begin
                tail <= i_squash_idx;
            end else if (i_alloc_fire && o_can_alloc) begin
                tail <= tail + req_pc;
            end
            case (state)
                RUN:     state <= i_squash ? SQ_WAIT : RUN;
                SQ_WAIT: state <= i_squash ? SQ_WAIT : RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Retiring more entries than are live would corrupt the head pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (free_pc <= count);
        end
    end

`ifdef LQ_ALLOC_PERF_EN
    // Saturating count of cycles where dispatch wanted entries but was held off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stall_cnt <= '0;
        end else if ((|i_alloc_req) && !o_can_alloc && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lq_idx_alloc_ctrl.sv
// tb/tb_lq_idx_alloc_ctrl.sv - scoreboard bench for lq_idx_alloc_ctrl against an absolute-count model
module tb_lq_idx_alloc_ctrl;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       alloc_req = '0;
    logic             alloc_fire = 1'b0;
    logic             can_alloc;
    logic [3:0][6:0]  alloc_idx;
    logic [1:0]       free_vld = '0;
    logic             squash = 1'b0;
    logic [6:0]       squash_idx = '0;
    logic [6:0]       head;
    logic [6:0]       tail;
    logic [6:0]       count;
    logic             empty;
    logic             full;
`ifdef LQ_ALLOC_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    lq_idx_alloc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_req  (alloc_req),
        .i_alloc_fire (alloc_fire),
        .o_can_alloc  (can_alloc),
        .o_alloc_idx  (alloc_idx),
        .i_free_vld   (free_vld),
        .i_squash     (squash),
        .i_squash_idx (squash_idx),
        .o_head       (head),
        .o_tail       (tail),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full)
`ifdef LQ_ALLOC_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        can;
        logic [3:0]  req;
        int unsigned idx [4];
        int unsigned head;
        int unsigned tail;
        int unsigned count;
        logic        empty;
        logic        full;
        int unsigned stall;
    } exp_t;

    exp_t exp_q[$];

    // Model: head/tail are absolute, never-wrapping entry numbers
    int unsigned m_head  = 0;
    int unsigned m_tail  = 0;
    bit          m_sqw   = 0;
    int unsigned m_stall = 0;

    function automatic int unsigned pc(input logic [3:0] v);
        int unsigned c = 0;
        for (int i = 0; i < 4; i++) if (v[i]) c++;
        return c;
    endfunction

    // lqIdx of an absolute entry number: flipped = which lap, idx = slot
    function automatic int unsigned enc(input int unsigned n);
        return ((n / 64) % 2) * 64 + (n % 64);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] req, input logic fire,
                        input logic [1:0] fv, input logic sq, input int unsigned sq_abs);
        exp_t        e;
        int unsigned cnt;
        int unsigned pre;
        @(negedge clk);
        #1;
        rst        = r;
        alloc_req  = req;
        alloc_fire = fire;
        free_vld   = fv;
        squash     = sq;
        squash_idx = 7'(enc(sq_abs));
        if (!r) begin
            m_head = 0; m_tail = 0; m_sqw = 0; m_stall = 0;
        end
        cnt     = m_tail - m_head;
        e.can   = r && !m_sqw && !sq && ((64 - cnt) >= pc(req));
        e.req   = req;
        pre     = 0;
        for (int k = 0; k < 4; k++) begin
            e.idx[k] = enc(m_tail + pre);
            if (req[k]) pre++;
        end
        e.head  = enc(m_head);
        e.tail  = enc(m_tail);
        e.count = cnt;
        e.empty = (cnt == 0);
        e.full  = (cnt == 64);
        e.stall = m_stall;
        exp_q.push_back(e);
        if (r) begin
            if ((req != 0) && !e.can) m_stall++;
            m_head += pc({2'b00, fv});
            if (sq) m_tail = sq_abs;
            else if (fire && e.can) m_tail += pc(req);
            m_sqw = sq;
        end
    endtask

    task automatic alloc_n(input int n, input logic [3:0] req);
        for (int i = 0; i < n; i++) step(1, req, 1, 2'b00, 0, 0);
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("can_alloc", {31'd0, can_alloc}, {31'd0, e.can});
                for (int k = 0; k < 4; k++)
                    if (e.req[k]) chk($sformatf("alloc_idx[%0d]", k), {25'd0, alloc_idx[k]}, e.idx[k]);
                chk("head", {25'd0, head}, e.head);
                chk("tail", {25'd0, tail}, e.tail);
                chk("count", {25'd0, count}, e.count);
                chk("empty", {31'd0, empty}, {31'd0, e.empty});
                chk("full", {31'd0, full}, {31'd0, e.full});
`ifdef LQ_ALLOC_PERF_EN
                chk("stall_cnt", stall_cnt, e.stall);
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt, f, lo, sqa;
        logic [1:0]  fv;
        logic [3:0]  rq;
        logic        sq;

        // reset state while requesting, then the basic allocation sequence
        step(0, 4'b1111, 1, 2'b00, 0, 0);
        step(1, 4'b1111, 1, 2'b00, 0, 0);
        step(1, 4'b1010, 1, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);

        // fill to full, refuse, free two, allocate across the flip
        step(0, 4'b0000, 0, 2'b00, 0, 0);
        alloc_n(16, 4'b1111);
        step(1, 4'b0001, 1, 2'b00, 0, 0);
        step(1, 4'b0000, 1, 2'b00, 0, 0);
        step(1, 4'b0001, 1, 2'b11, 0, 0);
        step(1, 4'b0011, 1, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);

        // squash with a simultaneous fire, stall one cycle, then a double squash
        step(0, 4'b0000, 0, 2'b00, 0, 0);
        alloc_n(5, 4'b1111);
        step(1, 4'b1111, 1, 2'b00, 1, 12);
        step(1, 4'b1111, 1, 2'b00, 0, 0);
        step(1, 4'b1111, 1, 2'b00, 0, 0);
        step(1, 4'b0001, 1, 2'b00, 1, 10);
        step(1, 4'b0001, 1, 2'b00, 1, 8);
        step(1, 4'b0001, 1, 2'b00, 0, 0);
        step(1, 4'b0001, 1, 2'b00, 1, m_tail);
        step(1, 4'b0000, 0, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);

        // random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 2400; i++) begin
            cnt = m_tail - m_head;
            if ((i / 300) % 2 == 0) f = $urandom_range(0, 2);
            else                    f = ($urandom_range(0, 3) == 0) ? 1 : 2;
            if (f > cnt) f = cnt;
            fv = (f == 0) ? 2'b00 : (f == 2) ? 2'b11 : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
            rq = 4'($urandom_range(0, 15));
            if ((i / 300) % 2 == 1 && $urandom_range(0, 1)) rq = rq & 4'b0001;
            sq = ($urandom_range(0, 19) == 0);
            lo  = m_head + f;
            sqa = sq ? lo + $urandom_range(0, m_tail - lo) : 0;
            step(1, rq, ($urandom_range(0, 3) != 0), fv, sq, sqa);
        end

        // asynchronous reset mid-run at count 30, then blocked-request cycles
        step(0, 4'b0000, 0, 2'b00, 0, 0);
        alloc_n(7, 4'b1111);
        step(1, 4'b0011, 1, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);
        step(0, 4'b1111, 1, 2'b00, 0, 0);
        step(1, 4'b1111, 1, 2'b00, 1, 0);
        step(1, 4'b0001, 1, 2'b00, 1, 0);
        step(1, 4'b0100, 0, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);
        step(1, 4'b0000, 0, 2'b00, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
